// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state type, default width and 1-bit subtract helper for serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic {SHIFT, HOLD} ser_state_t;
  localparam int SER_WIDTH_DEF = 4;
  function automatic logic [1:0] sub1(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction
endpackage

// File: rtl/sub1_cell.sv
// sub1_cell: combinational 1-bit full subtractor (d = a - b - bin, bout = borrow out)
module sub1_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  // one subtract step
  always_comb {bout, d} = sub1(a, b, bin);
endmodule

// File: rtl/serial_sub_unpack.sv
// serial_sub_unpack: LSB-first bit-serial subtractor that assembles a WIDTH-bit difference word.
// Optional SERIAL_SUB_INV_A_EN: minuend stream arrives active-low and is inverted on entry.
module serial_sub_unpack
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             a_eff, b_in, d, bout, accept;
`ifdef SERIAL_SUB_INV_A_EN
  assign a_eff = ~in_a;
`else
  assign a_eff = in_a;
`endif
  assign b_in      = (cnt_q == '0) ? in_bin : borrow_q;
  assign in_ready  = (state_q == SHIFT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_diff  = diff_q;
  assign out_bout  = bout_q;

  sub1_cell u_cell (
    .a    (a_eff),
    .b    (in_b),
    .bin  (b_in),
    .d    (d),
    .bout (bout)
  );

  // next state: absorb accepted beats in SHIFT, publish the word on the last beat, release on out_ready
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    shift_d  = shift_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    if (state_q == SHIFT && accept) begin
      shift_d[cnt_q] = d;
      borrow_d       = bout;
      cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        state_d = HOLD;
        diff_d  = shift_d;
        bout_d  = bout;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = SHIFT;
      shift_d = '0;
    end
  end

  // state registers, cleared asynchronously so a partial or held word is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SHIFT;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      shift_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      shift_q  <= shift_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end
endmodule
